// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan controller.
package disp_scan_ctrl_pkg;

    localparam int DIGITS     = 4;
    localparam int SCAN_IDX_W = 2;
    localparam int DIGIT_W    = 4;
    localparam int HEX_W      = DIGITS * DIGIT_W;

    localparam logic [SCAN_IDX_W-1:0] SCAN_FIRST = 2'd0;
    localparam logic [SCAN_IDX_W-1:0] SCAN_LAST  = 2'd3;

    // True when the scan index points at the last digit of a frame.
    function automatic logic is_last_digit(input logic [SCAN_IDX_W-1:0] idx);
        return (idx == SCAN_LAST);
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running scan prescaler: emits one tick every 2^SCAN_W enabled clocks.
module disp_prescaler #(
    parameter int SCAN_W = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [SCAN_W-1:0] cnt_r;

    // Counter advances only while enabled and wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {SCAN_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(SCAN_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en & (&cnt_r);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Display scan controller: digit scan index, frame-aligned content update and blink.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int SCAN_W       = 17,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_req,
    output logic                  wr_ready,
    input  logic [HEX_W-1:0]      wr_data,
    input  logic [DIGITS-1:0]     wr_point,
    input  logic [DIGITS-1:0]     wr_blink,
    output logic                  wr_done,
    output logic [HEX_W-1:0]      Hexs,
    output logic [SCAN_IDX_W-1:0] Scan,
    output logic [DIGITS-1:0]     point,
    output logic [DIGITS-1:0]     LES
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    logic                  digit_tick_s;
    logic                  frame_tick_s;
    logic                  accept_s;
    logic                  commit_s;

    logic [SCAN_IDX_W-1:0] scan_r;
    logic [HEX_W-1:0]      hexs_r;
    logic [DIGITS-1:0]     point_r;
    logic [DIGITS-1:0]     blink_mask_r;
    logic [DIGITS-1:0]     les_r;
    logic [FC_W-1:0]       frame_cnt_r;
    logic                  blink_phase_r;
    logic                  pend_valid_r;
    logic [HEX_W-1:0]      pend_hex_r;
    logic [DIGITS-1:0]     pend_point_r;
    logic [DIGITS-1:0]     pend_blink_r;
    logic                  wr_ready_r;
    logic                  wr_done_r;

    logic [SCAN_IDX_W-1:0] scan_nxt_s;
    logic [FC_W-1:0]       frame_cnt_nxt_s;
    logic                  blink_phase_nxt_s;
    logic [DIGITS-1:0]     blink_mask_nxt_s;

    disp_prescaler #(
        .SCAN_W (SCAN_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (digit_tick_s)
    );

    // A commit needs data already pending before the frame tick, so a write
    // accepted on the tick cycle itself waits a whole frame.
    assign frame_tick_s = digit_tick_s & is_last_digit(scan_r);
    assign accept_s     = wr_req & ~pend_valid_r;
    assign commit_s     = frame_tick_s & pend_valid_r;

    // Next-state of the scan index, blink timing and visible blink mask.
    always_comb begin
        scan_nxt_s        = scan_r;
        frame_cnt_nxt_s   = frame_cnt_r;
        blink_phase_nxt_s = blink_phase_r;
        blink_mask_nxt_s  = blink_mask_r;

        if (digit_tick_s) begin
            scan_nxt_s = scan_r + {{(SCAN_IDX_W-1){1'b0}}, 1'b1};
        end else begin
            scan_nxt_s = scan_r;
        end

        if (frame_tick_s) begin
            if (frame_cnt_r == FC_LAST) begin
                frame_cnt_nxt_s   = {FC_W{1'b0}};
                blink_phase_nxt_s = ~blink_phase_r;
            end else begin
                frame_cnt_nxt_s   = frame_cnt_r + FC_ONE;
                blink_phase_nxt_s = blink_phase_r;
            end
        end else begin
            frame_cnt_nxt_s   = frame_cnt_r;
            blink_phase_nxt_s = blink_phase_r;
        end

        if (commit_s) begin
            blink_mask_nxt_s = pend_blink_r;
        end else begin
            blink_mask_nxt_s = blink_mask_r;
        end
    end

    // Scan index, blink state and the blank mask derived from them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_r        <= SCAN_FIRST;
            frame_cnt_r   <= {FC_W{1'b0}};
            blink_phase_r <= 1'b0;
            blink_mask_r  <= {DIGITS{1'b0}};
            les_r         <= {DIGITS{1'b0}};
        end else begin
            scan_r        <= scan_nxt_s;
            frame_cnt_r   <= frame_cnt_nxt_s;
            blink_phase_r <= blink_phase_nxt_s;
            blink_mask_r  <= blink_mask_nxt_s;
            les_r         <= blink_mask_nxt_s & {DIGITS{blink_phase_nxt_s}};
        end
    end

    // Single-entry write buffer: capture when empty, release at a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_hex_r   <= {HEX_W{1'b0}};
            pend_point_r <= {DIGITS{1'b0}};
            pend_blink_r <= {DIGITS{1'b0}};
            wr_ready_r   <= 1'b1;
        end else if (accept_s) begin
            pend_valid_r <= 1'b1;
            pend_hex_r   <= wr_data;
            pend_point_r <= wr_point;
            pend_blink_r <= wr_blink;
            wr_ready_r   <= 1'b0;
        end else if (commit_s) begin
            pend_valid_r <= 1'b0;
            pend_hex_r   <= pend_hex_r;
            pend_point_r <= pend_point_r;
            pend_blink_r <= pend_blink_r;
            wr_ready_r   <= 1'b1;
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_hex_r   <= pend_hex_r;
            pend_point_r <= pend_point_r;
            pend_blink_r <= pend_blink_r;
            wr_ready_r   <= wr_ready_r;
        end
    end

    // Displayed contents change only on the edge where Scan wraps 3 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hexs_r    <= {HEX_W{1'b0}};
            point_r   <= {DIGITS{1'b0}};
            wr_done_r <= 1'b0;
        end else if (commit_s) begin
            hexs_r    <= pend_hex_r;
            point_r   <= pend_point_r;
            wr_done_r <= 1'b1;
        end else begin
            hexs_r    <= hexs_r;
            point_r   <= point_r;
            wr_done_r <= 1'b0;
        end
    end

    assign wr_ready = wr_ready_r;
    assign wr_done  = wr_done_r;
    assign Hexs     = hexs_r;
    assign Scan     = scan_r;
    assign point    = point_r;
    assign LES      = les_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with SCAN_W=2, BLINK_FRAMES=2.
module tb_disp_scan_ctrl;

    localparam int SCAN_W       = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int CLK_PER_DIG  = 1 << SCAN_W;
    localparam int CLK_PER_FRM  = 4 * CLK_PER_DIG;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        wr_req = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = 16'h0000;
    logic [3:0]  wr_point = 4'h0;
    logic [3:0]  wr_blink = 4'h0;
    logic        wr_done;
    logic [15:0] Hexs;
    logic [1:0]  Scan;
    logic [3:0]  point;
    logic [3:0]  LES;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: enabled-clock count since reset plus a write buffer.
    int          m_n = 0;
    logic [15:0] m_hex = 16'h0000;
    logic [3:0]  m_pt = 4'h0;
    logic [3:0]  m_blink = 4'h0;
    logic        m_pend = 1'b0;
    logic [15:0] p_hex = 16'h0000;
    logic [3:0]  p_pt = 4'h0;
    logic [3:0]  p_blink = 4'h0;
    logic        m_done = 1'b0;

    disp_scan_ctrl #(
        .SCAN_W       (SCAN_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wr_req   (wr_req),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_point (wr_point),
        .wr_blink (wr_blink),
        .wr_done  (wr_done),
        .Hexs     (Hexs),
        .Scan     (Scan),
        .point    (point),
        .LES      (LES)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock edge of the reference rules using the inputs seen at that edge.
    task automatic model_edge();
        logic ft;
        logic commit;
        logic accept;
        if (!rst_n) begin
            m_n = 0; m_hex = 16'h0000; m_pt = 4'h0; m_blink = 4'h0;
            m_pend = 1'b0; m_done = 1'b0;
        end else begin
            ft     = en && ((m_n % CLK_PER_FRM) == CLK_PER_FRM - 1);
            commit = ft && m_pend;
            accept = wr_req && !m_pend;
            m_done = commit;
            if (commit) begin
                m_hex = p_hex; m_pt = p_pt; m_blink = p_blink; m_pend = 1'b0;
            end
            if (accept) begin
                p_hex = wr_data; p_pt = wr_point; p_blink = wr_blink; m_pend = 1'b1;
            end
            if (en) m_n++;
        end
    endtask

    // One clock: advance model at the edge, compare every output shortly after.
    task automatic cyc();
        int   scan_e;
        logic phase_e;
        @(posedge clk);
        model_edge();
        #1;
        scan_e  = (m_n / CLK_PER_DIG) % 4;
        phase_e = ((m_n / (CLK_PER_FRM * BLINK_FRAMES)) % 2) == 1;
        check_val("scan",  {30'd0, Scan},      scan_e);
        check_val("hexs",  {16'd0, Hexs},      {16'd0, m_hex});
        check_val("point", {28'd0, point},     {28'd0, m_pt});
        check_val("les",   {28'd0, LES},       {28'd0, m_blink & {4{phase_e}}});
        check_val("ready", {31'd0, wr_ready},  {31'd0, !m_pend});
        check_val("done",  {31'd0, wr_done},   {31'd0, m_done});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Run until the model commits, bounded; an expired bound counts as a failure.
    task automatic run_to_commit(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!m_done && k < budget);
        check_val({tag, "_commit_seen"}, {31'd0, m_done}, 32'd1);
    endtask

    task automatic write_one(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        wr_req = 1'b1; wr_data = d; wr_point = p; wr_blink = b;
        cyc();
        wr_req = 1'b0;
    endtask

    initial begin
        // 1: reset held three clocks with en=1
        rst_n = 1'b0; en = 1'b1;
        run(3);
        check_val("t1_scan",  {30'd0, Scan},     32'd0);
        check_val("t1_hexs",  {16'd0, Hexs},     32'd0);
        check_val("t1_les",   {28'd0, LES},      32'd0);
        check_val("t1_ready", {31'd0, wr_ready}, 32'd1);
        check_val("t1_done",  {31'd0, wr_done},  32'd0);
        rst_n = 1'b1;

        // 2: free-running scan rotation
        run(32);

        // 3: write at Scan=1, commit on the 3 -> 0 edge
        for (int k = 0; k < 20 && ((m_n / CLK_PER_DIG) % 4) != 1; k++) cyc();
        check_val("t3_at_scan1", {30'd0, Scan}, 32'd1);
        write_one(16'h1234, 4'b0101, 4'b0000);
        check_val("t3_ready_low", {31'd0, wr_ready}, 32'd0);
        check_val("t3_hexs_old",  {16'd0, Hexs},     32'd0);

        // 4: second request while pending is ignored
        write_one(16'hBEEF, 4'b1111, 4'b1111);
        run_to_commit("t4", 40);
        check_val("t4_hexs",  {16'd0, Hexs},  32'h1234);
        check_val("t4_point", {28'd0, point}, 32'h5);
        cyc();
        check_val("t4_done_one_clk", {31'd0, wr_done}, 32'd0);

        // 5: accept on the frame-tick cycle, shown only after the next frame
        for (int k = 0; k < 40 && (m_n % CLK_PER_FRM) != CLK_PER_FRM - 1; k++) cyc();
        write_one(16'hA5A5, 4'b0011, 4'b0000);
        check_val("t5_not_yet", {16'd0, Hexs}, 32'h1234);
        run(CLK_PER_FRM - 1);
        check_val("t5_still_old", {16'd0, Hexs}, 32'h1234);
        cyc();
        check_val("t5_hexs", {16'd0, Hexs},    32'hA5A5);
        check_val("t5_done", {31'd0, wr_done}, 32'd1);

        // 6: blink on digit 3, then reset with a write pending
        write_one(16'h0F0F, 4'b1000, 4'b1000);
        run_to_commit("t6", 40);
        run(4 * CLK_PER_FRM * BLINK_FRAMES);
        write_one(16'h7777, 4'b0001, 4'b0001);
        rst_n = 1'b0;
        run(2);
        check_val("t6_rst_hexs",  {16'd0, Hexs},     32'd0);
        check_val("t6_rst_ready", {31'd0, wr_ready}, 32'd1);
        check_val("t6_rst_les",   {28'd0, LES},      32'd0);
        rst_n = 1'b1;
        run(2 * CLK_PER_FRM);
        check_val("t6_dropped", {16'd0, Hexs}, 32'd0);

        // Randomized traffic with en gaps and occasional resets
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            wr_req   = ($urandom_range(0, 5) == 0);
            wr_data  = 16'($urandom);
            wr_point = 4'($urandom);
            wr_blink = 4'($urandom);
            rst_n    = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n = 1'b1; wr_req = 1'b0; en = 1'b1;
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
